// File: rtl/buffer_pop_streamer.sv
// Drain stage for the push/pop buffer: issues pops, captures data_out into a 2-entry skid and
// re-emits it as a valid/ready stream framed into BURST_LEN-beat bursts. STREAMER_PARITY_EN adds m_parity.
module buffer_pop_streamer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BURST_LEN  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  buf_is_empty,
  input  logic                  buf_push,
  input  logic                  buf_err,
  input  logic [DATA_WIDTH-1:0] buf_data_out,
  output logic                  buf_pop_en,
  output logic                  buf_pop,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic                  err_seen
`ifdef STREAMER_PARITY_EN
  ,
  output logic                  m_parity
`endif
);

  localparam int unsigned BeatW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BeatW-1:0] LastBeat = BeatW'(BURST_LEN - 1);

  typedef enum logic [1:0] {StIdle, StStream, StFlush} state_e;

  state_e state_q, state_d;

  logic                  inflight_q;
  logic [1:0]            count_q;
  logic                  rd_ptr_q;
  logic                  wr_ptr_q;
  logic [DATA_WIDTH-1:0] mem_q [2];
  logic [BeatW-1:0]      beat_q;
  logic                  err_seen_q;

  logic       skid_wr;
  logic       skid_rd;
  logic       pop;
  logic [1:0] occupancy;

  assign skid_wr = inflight_q;
  assign skid_rd = m_valid & m_ready;

  // A head word leaving this cycle frees its slot for the word a pop issued now lands in two
  // cycles later, which is what keeps back-to-back pops at one word per cycle.
  assign occupancy = count_q - {1'b0, skid_rd} + {1'b0, inflight_q};

  assign pop = (state_q == StStream) & ~buf_is_empty & ~buf_push & ~buf_err &
               (occupancy < 2'd2);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; stop takes priority over start
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (start && !stop) begin
          state_d = StStream;
        end
      end
      StStream: begin
        if (stop || buf_err) begin
          state_d = StFlush;
        end
      end
      StFlush: begin
        if (!inflight_q && (count_q == 2'd0)) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy       = (state_q != StIdle);
    buf_pop    = pop;
    buf_pop_en = pop;
  end

  // Skid control, beat counter and sticky error
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inflight_q <= 1'b0;
      count_q    <= 2'd0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      beat_q     <= '0;
      err_seen_q <= 1'b0;
    end else begin
      inflight_q <= pop;
      count_q    <= count_q + {1'b0, skid_wr} - {1'b0, skid_rd};
      if (skid_wr) begin
        wr_ptr_q <= ~wr_ptr_q;
      end
      if (skid_rd) begin
        rd_ptr_q <= ~rd_ptr_q;
        beat_q   <= (beat_q == LastBeat) ? '0 : beat_q + BeatW'(1);
      end
      if (buf_err) begin
        err_seen_q <= 1'b1;
      end
    end
  end

  // Storage needs no reset: entries are only observed while counted as occupied
  always_ff @(posedge clk) begin
    if (skid_wr) begin
      mem_q[wr_ptr_q] <= buf_data_out;
    end
  end

  assign m_valid  = (count_q != 2'd0);
  assign m_data   = m_valid ? mem_q[rd_ptr_q] : '0;
  assign m_last   = m_valid & (beat_q == LastBeat);
  assign err_seen = err_seen_q;

`ifdef STREAMER_PARITY_EN
  logic par_q [2];

  always_ff @(posedge clk) begin
    if (skid_wr) begin
      par_q[wr_ptr_q] <= ^buf_data_out;
    end
  end

  assign m_parity = m_valid & par_q[rd_ptr_q];
`endif

endmodule

// File: tb/tb_buffer_pop_streamer.sv
// Self-checking bench for buffer_pop_streamer: models the push/pop buffer and scoreboards the
// output stream, with a vector table for the basic burst and directed multi-cycle sequences.
module tb_buffer_pop_streamer;

  localparam int DW = 8;
  localparam int BL = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          buf_is_empty = 1'b1;
  logic          buf_push = 1'b0;
  logic          buf_err = 1'b0;
  logic [DW-1:0] buf_data_out = '0;
  logic          buf_pop_en;
  logic          buf_pop;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          busy;
  logic          err_seen;

  buffer_pop_streamer #(
    .DATA_WIDTH(DW),
    .BURST_LEN (BL)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .stop        (stop),
    .buf_is_empty(buf_is_empty),
    .buf_push    (buf_push),
    .buf_err     (buf_err),
    .buf_data_out(buf_data_out),
    .buf_pop_en  (buf_pop_en),
    .buf_pop     (buf_pop),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .m_last      (m_last),
    .busy        (busy),
    .err_seen    (err_seen)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
  } exp_t;

  typedef struct {
    logic          start;
    logic          pop;
    logic          valid;
    logic [DW-1:0] data;
    logic          last;
  } vec_t;

  logic [DW-1:0] bq[$];
  exp_t          sb[$];
  int            n_chk = 0;
  int            n_fail = 0;
  int            exp_beat = 0;
  int            outstanding = 0;
  logic          stall_prev = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic          prev_last = 1'b0;
  logic          bp_seen = 1'b0;
  logic [DW-1:0] push_word = 8'hA0;
  logic          smp_pop, smp_valid, smp_last, smp_busy, smp_err;
  logic [DW-1:0] smp_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic load(input logic [DW-1:0] w);
    bq.push_back(w);
    sb.push_back('{d: w, l: (exp_beat == BL - 1)});
    exp_beat = (exp_beat + 1) % BL;
  endtask

  task automatic clear_model();
    bq.delete();
    sb.delete();
    exp_beat    = 0;
    outstanding = 0;
    stall_prev  = 1'b0;
  endtask

  // One clock: inputs already driven by the caller at posedge+1, sample at negedge
  task automatic cycle();
    exp_t e;
    buf_is_empty = (bq.size() == 0);
    @(negedge clk);
    smp_pop   = buf_pop;
    smp_valid = m_valid;
    smp_data  = m_data;
    smp_last  = m_last;
    smp_busy  = busy;
    smp_err   = err_seen;
    if (buf_pop || buf_pop_en) check("pop_en_match", buf_pop_en, buf_pop);
    if (buf_push) check("pop_vs_push", buf_pop, 0);
    if (buf_is_empty) check("pop_when_empty", buf_pop, 0);
    if (stall_prev) begin
      check("hold_valid", m_valid, 1);
      check("hold_data", m_data, prev_data);
      check("hold_last", m_last, prev_last);
    end
    if (!buf_is_empty && !buf_pop && m_valid && !m_ready && outstanding == 2) bp_seen = 1'b1;
    if (m_valid && m_ready) begin
      if (sb.size() == 0) begin
        check("extra_word", m_data, 32'hFFFF);
      end else begin
        e = sb.pop_front();
        check("sb_data", m_data, e.d);
        check("sb_last", m_last, e.l);
      end
      outstanding--;
    end
    if (buf_pop) outstanding++;
    check("skid_bound", outstanding <= 2, 1);
    stall_prev = m_valid & ~m_ready;
    prev_data  = m_data;
    prev_last  = m_last;
    @(posedge clk);
    #1;
    if (smp_pop) buf_data_out = (bq.size() > 0) ? bq.pop_front() : 8'hEE;
    if (buf_push) begin
      load(push_word);
      push_word = push_word + 8'd1;
    end
    start   = 1'b0;
    stop    = 1'b0;
    buf_err = 1'b0;
  endtask

  task automatic run_until_drained(input int budget);
    int n = 0;
    while (sb.size() > 0 && n < budget) begin
      cycle();
      n++;
    end
    check("drain_timeout", sb.size(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pop_en"}, buf_pop_en, 0);
    check({tag, "_pop"}, buf_pop, 0);
    check({tag, "_valid"}, m_valid, 0);
    check({tag, "_data"}, m_data, 0);
    check({tag, "_last"}, m_last, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_err_seen"}, err_seen, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    buf_push = 1'b0;
    buf_err = 1'b0;
    m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    clear_model();
    buf_is_empty = 1'b1;
    check_all_zero("reset");
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[8];
    int   pops;

    // 1: basic 4-word burst, one word per cycle, first m_valid two cycles after first pop
    tbl[0] = '{start: 1, pop: 0, valid: 0, data: 8'h00, last: 0};
    tbl[1] = '{start: 0, pop: 1, valid: 0, data: 8'h00, last: 0};
    tbl[2] = '{start: 0, pop: 1, valid: 0, data: 8'h00, last: 0};
    tbl[3] = '{start: 0, pop: 1, valid: 1, data: 8'h11, last: 0};
    tbl[4] = '{start: 0, pop: 1, valid: 1, data: 8'h22, last: 0};
    tbl[5] = '{start: 0, pop: 0, valid: 1, data: 8'h33, last: 0};
    tbl[6] = '{start: 0, pop: 0, valid: 1, data: 8'h44, last: 1};
    tbl[7] = '{start: 0, pop: 0, valid: 0, data: 8'h00, last: 0};

    do_reset();
    load(8'h11);
    load(8'h22);
    load(8'h33);
    load(8'h44);
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      start = tbl[i].start;
      cycle();
      check($sformatf("t1_pop[%0d]", i), smp_pop, tbl[i].pop);
      check($sformatf("t1_valid[%0d]", i), smp_valid, tbl[i].valid);
      if (tbl[i].valid) begin
        check($sformatf("t1_data[%0d]", i), smp_data, tbl[i].data);
        check($sformatf("t1_last[%0d]", i), smp_last, tbl[i].last);
      end
    end

    // 2: back-pressure on cycles 3-7 of a 6-word run
    for (int i = 0; i < 6; i++) load(8'h60 + 8'(i));
    bp_seen = 1'b0;
    for (int k = 0; k < 25; k++) begin
      m_ready = !(k >= 3 && k <= 7);
      cycle();
    end
    check("t2_backpressure_seen", bp_seen, 1);
    check("t2_drained", sb.size(), 0);

    // 3: upstream pushes on alternate cycles
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) load(8'h30 + 8'(i));
    for (int k = 0; k < 12; k++) begin
      buf_push = (k % 2 == 1);
      cycle();
    end
    buf_push = 1'b0;
    run_until_drained(30);

    // 4: single word, then the buffer stays empty
    load(8'h5A);
    start = 1'b1;
    pops = 0;
    for (int k = 0; k < 8; k++) begin
      cycle();
      pops += int'(smp_pop);
    end
    check("t4_pops", pops, 1);
    check("t4_busy", smp_busy, 1);
    check("t4_pop_idle", smp_pop, 0);
    check("t4_drained", sb.size(), 0);

    // 5: stop with one word in flight and one in the skid
    m_ready = 1'b0;
    load(8'hC1);
    load(8'hC2);
    cycle();
    cycle();
    stop = 1'b1;
    cycle();
    check("t5_pop_at_stop", smp_pop, 0);
    bq.push_back(8'h99);
    m_ready = 1'b1;
    pops = 0;
    for (int k = 0; k < 10 && sb.size() > 0; k++) begin
      cycle();
      pops += int'(smp_pop);
    end
    check("t5_drained", sb.size(), 0);
    cycle();
    pops += int'(smp_pop);
    cycle();
    pops += int'(smp_pop);
    check("t5_no_pops", pops, 0);
    check("t5_idle", smp_busy, 0);
    bq.delete();

    // 6a: buffer error in STREAM
    load(8'hE1);
    load(8'hE2);
    start = 1'b1;
    cycle();
    cycle();
    cycle();
    buf_err = 1'b1;
    cycle();
    cycle();
    check("t6_err_seen", smp_err, 1);
    check("t6_flush_busy", smp_busy, 1);
    run_until_drained(10);
    cycle();
    cycle();
    check("t6_idle", smp_busy, 0);
    check("t6_err_sticky", smp_err, 1);

    // 6b: reset in the middle of a burst
    for (int i = 0; i < 4; i++) load(8'h70 + 8'(i));
    start = 1'b1;
    for (int k = 0; k < 4; k++) cycle();
    check("t6_valid_before_rst", smp_valid, 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_all_zero("midrst");
    clear_model();
    rst_n = 1'b1;

    // Beat counter restarts after reset
    for (int i = 0; i < 4; i++) load(8'h80 + 8'(i));
    m_ready = 1'b1;
    start = 1'b1;
    run_until_drained(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
